// File: rtl/shift_register_128to32.sv
// shift_register_128to32: serializes one WORD_W*NUM_WORDS-bit block into NUM_WORDS
//    words, most significant word first, so a block from the 32-to-128 input
//    shifter round-trips unchanged.
// Latency: first word is valid one cycle after the load transfer; back-to-back
//    blocks stream with no bubble (4 words / 4 cycles).
// Backpressure: out_valid/out_ready stream. A stalled word holds data_out,
//    out_last and count. load_ready opens only in IDLE or on the final-word
//    transfer, so upstream holds a block while one is in flight.
// Ports:
//    clk, reset (sync, active-low), flush (sync abort to IDLE)
//    data_in/load/load_ready        : block input handshake
//    data_out/out_valid/out_ready   : word output handshake
//    out_last                       : data_out is the final word of its block
//    busy                           : a block is held (SEND)
module shift_register_128to32 #(
   parameter int WORD_W    = 32,
   parameter int NUM_WORDS = 4
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        flush,
   input  logic [WORD_W*NUM_WORDS-1:0] data_in,
   input  logic                        load,
   output logic                        load_ready,
   output logic [WORD_W-1:0]           data_out,
   output logic                        out_valid,
   input  logic                        out_ready,
   output logic                        out_last,
   output logic                        busy
);

   localparam int BLK_W = WORD_W * NUM_WORDS;
   localparam int CNT_W = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_WORDS - 1);

   typedef enum logic {
      IDLE = 1'b0,
      SEND = 1'b1
   } state_t;

   state_t              state_q, state_d;
   logic [CNT_W-1:0]    count_q, count_d;
   logic [BLK_W-1:0]    block_q, block_d;
   logic [WORD_W-1:0]   data_out_q, data_out_d;
   logic                out_valid_q, out_valid_d;
   logic                out_last_q, out_last_d;
   logic                busy_q, busy_d;

   logic                out_xfer;
   logic                load_xfer;
   logic [CNT_W-1:0]    count_inc;

   // Word idx of a block, counting from the most significant end.
   function automatic logic [WORD_W-1:0] word_at(input logic [BLK_W-1:0] blk,
                                                 input logic [CNT_W-1:0] idx);
      word_at = '0;
      for (int i = 0; i < NUM_WORDS; i++) begin
         if (idx == CNT_W'(i)) begin
            word_at = blk[BLK_W-1-WORD_W*i -: WORD_W];
         end
      end
   endfunction

   // Ready either when empty or when the last word leaves this cycle; this is
   // what lets the next block follow with no bubble. Never depends on load.
   assign load_ready = (state_q == IDLE) ||
                       ((count_q == LAST_IDX) && out_ready && out_valid_q);

   assign out_xfer  = out_valid_q && out_ready;
   // flush discards a load even when load_ready is high.
   assign load_xfer = load && load_ready && !flush;
   assign count_inc = count_q + CNT_W'(1);

   always_comb begin
      state_d     = state_q;
      count_d     = count_q;
      block_d     = block_q;
      data_out_d  = data_out_q;
      out_valid_d = out_valid_q;
      out_last_d  = out_last_q;
      busy_d      = busy_q;

      if (flush) begin
         state_d     = IDLE;
         count_d     = '0;
         out_valid_d = 1'b0;
         out_last_d  = 1'b0;
         busy_d      = 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (load_xfer) begin
                  state_d     = SEND;
                  count_d     = '0;
                  block_d     = data_in;
                  data_out_d  = data_in[BLK_W-1 -: WORD_W];
                  out_valid_d = 1'b1;
                  out_last_d  = (LAST_IDX == '0);
                  busy_d      = 1'b1;
               end
            end
            SEND: begin
               if (out_xfer) begin
                  if (count_q == LAST_IDX) begin
                     if (load_xfer) begin
                        count_d     = '0;
                        block_d     = data_in;
                        data_out_d  = data_in[BLK_W-1 -: WORD_W];
                        out_valid_d = 1'b1;
                        out_last_d  = (LAST_IDX == '0);
                        busy_d      = 1'b1;
                     end else begin
                        // data_out keeps its last value; it is don't-care once invalid.
                        state_d     = IDLE;
                        count_d     = '0;
                        out_valid_d = 1'b0;
                        out_last_d  = 1'b0;
                        busy_d      = 1'b0;
                     end
                  end else begin
                     count_d    = count_inc;
                     data_out_d = word_at(block_q, count_inc);
                     out_last_d = (count_inc == LAST_IDX);
                  end
               end
            end
            default: begin
               state_d = IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q     <= IDLE;
         count_q     <= '0;
         block_q     <= '0;
         data_out_q  <= '0;
         out_valid_q <= 1'b0;
         out_last_q  <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         count_q     <= count_d;
         block_q     <= block_d;
         data_out_q  <= data_out_d;
         out_valid_q <= out_valid_d;
         out_last_q  <= out_last_d;
         busy_q      <= busy_d;
      end
   end

   assign data_out  = data_out_q;
   assign out_valid = out_valid_q;
   assign out_last  = out_last_q;
   assign busy      = busy_q;

endmodule

// File: tb/tb_shift_register_128to32.sv
// tb_shift_register_128to32: directed-vector bench for the 128-to-32 serializer.
// Inputs change 1 time unit after the rising edge; outputs are observed on the
// falling edge, so each observation reflects the state the next edge acts on.
module tb_shift_register_128to32;

   localparam logic [127:0] B1 = 128'h00112233_44556677_8899AABB_CCDDEEFF;
   localparam logic [127:0] B2 = 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D;

   logic          clk = 1'b0;
   logic          reset;
   logic          flush;
   logic [127:0]  data_in;
   logic          load;
   logic          load_ready;
   logic [31:0]   data_out;
   logic          out_valid;
   logic          out_ready;
   logic          out_last;
   logic          busy;

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   shift_register_128to32 dut (
      .clk        (clk),
      .reset      (reset),
      .flush      (flush),
      .data_in    (data_in),
      .load       (load),
      .load_ready (load_ready),
      .data_out   (data_out),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_last   (out_last),
      .busy       (busy)
   );

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, obs, exp);
   endtask

   function automatic logic [31:0] wd(input logic [127:0] b, input int i);
      return b[127-32*i -: 32];
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic mid();
      @(negedge clk);
   endtask

   task automatic chk_word(input string tag, input logic [127:0] b, input int i);
      check($sformatf("%s w%0d valid", tag, i), 128'(out_valid), 128'(1'b1));
      check($sformatf("%s w%0d data", tag, i), 128'(data_out), 128'(wd(b, i)));
      check($sformatf("%s w%0d last", tag, i), 128'(out_last), 128'(i == 3));
   endtask

   task automatic chk_idle(input string tag);
      check({tag, " valid"}, 128'(out_valid), 128'(1'b0));
      check({tag, " busy"}, 128'(busy), 128'(1'b0));
      check({tag, " last"}, 128'(out_last), 128'(1'b0));
      check({tag, " load_ready"}, 128'(load_ready), 128'(1'b1));
   endtask

   logic [6:0] pat;
   int         idx;

   initial begin
      reset = 1'b0; flush = 1'b0; load = 1'b0; out_ready = 1'b0; data_in = '0;
      repeat (3) tick();
      reset = 1'b1;
      mid();
      chk_idle("rst");
      check("rst data", 128'(data_out), 128'(32'h0));

      // Single block, out_ready high throughout.
      tick(); load = 1'b1; data_in = B1; out_ready = 1'b1;
      mid();
      check("single load_ready", 128'(load_ready), 128'(1'b1));
      for (int i = 0; i < 4; i++) begin
         tick(); load = 1'b0; data_in = '0;
         mid();
         chk_word("single", B1, i);
         check($sformatf("single w%0d load_ready", i), 128'(load_ready), 128'(i == 3));
         check($sformatf("single w%0d busy", i), 128'(busy), 128'(1'b1));
      end
      tick();
      mid();
      chk_idle("single end");

      // Backpressure pattern 1,0,0,1,0,1,1.
      tick(); load = 1'b1; data_in = B1; out_ready = 1'b0;
      pat = 7'b1001011;
      idx = 0;
      for (int k = 0; k < 7; k++) begin
         tick(); load = 1'b0; out_ready = pat[6-k];
         mid();
         chk_word($sformatf("bp c%0d", k), B1, idx);
         if (pat[6-k]) idx++;
      end
      tick(); out_ready = 1'b1;
      mid();
      chk_idle("bp end");

      // Back-to-back: second block held on load during the first.
      tick(); load = 1'b1; data_in = B1; out_ready = 1'b1;
      mid();
      for (int i = 0; i < 4; i++) begin
         tick(); load = 1'b1; data_in = B2;
         mid();
         chk_word("b2b A", B1, i);
         check($sformatf("b2b A w%0d load_ready", i), 128'(load_ready), 128'(i == 3));
      end
      for (int i = 0; i < 4; i++) begin
         tick(); load = 1'b0;
         mid();
         chk_word("b2b B", B2, i);
         check($sformatf("b2b B w%0d load_ready", i), 128'(load_ready), 128'(i == 3));
      end
      tick();
      mid();
      chk_idle("b2b end");

      // Load while busy, with a stall on word 1.
      tick(); load = 1'b1; data_in = B1; out_ready = 1'b1;
      mid();
      tick(); load = 1'b0;
      mid();
      chk_word("lwb", B1, 0);
      tick(); load = 1'b1; data_in = B2; out_ready = 1'b0;
      mid();
      chk_word("lwb stall", B1, 1);
      check("lwb stall load_ready", 128'(load_ready), 128'(1'b0));
      tick(); out_ready = 1'b1;
      mid();
      chk_word("lwb", B1, 1);
      check("lwb w1 load_ready", 128'(load_ready), 128'(1'b0));
      tick();
      mid();
      chk_word("lwb", B1, 2);
      check("lwb w2 load_ready", 128'(load_ready), 128'(1'b0));
      tick();
      mid();
      chk_word("lwb", B1, 3);
      check("lwb w3 load_ready", 128'(load_ready), 128'(1'b1));
      tick(); load = 1'b0;
      for (int i = 0; i < 4; i++) begin
         if (i > 0) tick();
         mid();
         chk_word("lwb new", B2, i);
      end
      tick();
      mid();
      chk_idle("lwb end");

      // Flush after two words have transferred.
      tick(); load = 1'b1; data_in = B1; out_ready = 1'b1;
      mid();
      for (int i = 0; i < 2; i++) begin
         tick(); load = 1'b0;
         mid();
         chk_word("flush", B1, i);
      end
      tick(); flush = 1'b1; load = 1'b1; data_in = B2;
      mid();
      chk_word("flush", B1, 2);
      tick(); flush = 1'b0; load = 1'b0;
      mid();
      chk_idle("flush after");
      // Flush in IDLE wins over a load that sees load_ready=1.
      tick(); flush = 1'b1; load = 1'b1; data_in = B2;
      mid();
      check("flush idle load_ready", 128'(load_ready), 128'(1'b1));
      tick(); flush = 1'b0; load = 1'b0;
      mid();
      chk_idle("flush idle");
      tick(); load = 1'b1; data_in = B2;
      mid();
      for (int i = 0; i < 4; i++) begin
         tick(); load = 1'b0;
         mid();
         chk_word("post flush", B2, i);
      end
      tick();
      mid();
      chk_idle("post flush end");

      // Reset held low for 3 cycles mid-block, with load asserted throughout.
      tick(); load = 1'b1; data_in = B1; out_ready = 1'b1;
      mid();
      tick(); load = 1'b0;
      mid();
      chk_word("mrst", B1, 0);
      tick(); reset = 1'b0; load = 1'b1; data_in = B2;
      mid();
      chk_word("mrst", B1, 1);
      tick();
      mid();
      chk_idle("mrst held");
      check("mrst held data", 128'(data_out), 128'(32'h0));
      tick();
      tick(); reset = 1'b1; load = 1'b0;
      mid();
      chk_idle("mrst release");
      check("mrst release data", 128'(data_out), 128'(32'h0));
      tick();
      mid();
      check("mrst after valid", 128'(out_valid), 128'(1'b0));

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
